// File: rtl/fetch_unit.sv
// Instruction fetch front end: drives the PC to a combinational instruction memory,
// buffers {pc, ins} pairs in a small FIFO and hands them to decode via valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] PC_STEP    = 32'd1,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] fPC,
  input  logic [31:0] ins,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_ins,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic [31:0] fetch_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  logic [31:0]   pc;
  logic [31:0]   ins_buf [FIFO_DEPTH];
  logic [31:0]   pc_buf  [FIFO_DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;
  logic          pop;
  logic          push;

  assign fPC       = pc;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready & ~redirect_valid;
  // A simultaneous pop frees a slot, so a full buffer can still accept a fetch.
  assign push      = ~halt & ~redirect_valid & ((count < DEPTH) | pop);
  assign out_ins   = out_valid ? ins_buf[head] : '0;
  assign out_pc    = out_valid ? pc_buf[head]  : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      fetch_count <= '0;
    end else if (redirect_valid) begin
      pc    <= redirect_pc;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        ins_buf[tail] <= ins;
        pc_buf[tail]  <= pc;
        tail          <= tail + AW'(1);
        pc            <= pc + PC_STEP;
        fetch_count   <= fetch_count + 32'd1;
      end
      if (pop)
        head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a random phase,
// all compared against a queue-based reference model of the fetch buffer.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fpc;
  logic [31:0] ins;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic [31:0] out_ins;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;
  logic [31:0] fetch_count;

  int compared = 0;
  int mismatched = 0;

  logic [63:0] mq[$];
  logic [31:0] mpc;
  logic [31:0] mfc;
  logic [31:0] saved_pc;
  logic [31:0] saved_fc;

  fetch_unit #(.RESET_PC(32'h0), .PC_STEP(32'd1), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .fPC(fpc), .ins(ins), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ins(out_ins), .out_pc(out_pc),
    .out_ready(out_ready), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h0022_2020;
    if (a == 32'd1) return 32'h0022_2022;
    return (a * 32'h9E37_79B1) ^ 32'h0123_4567;
  endfunction

  assign ins = mem_word(fpc);

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the reference model, then compare after the edge.
  task automatic apply_stimulus(input logic rstn, input logic rdy, input logic hlt,
                                input logic rv, input logic [31:0] rpc);
    logic pop_m;
    logic push_m;
    rst_n = rstn; out_ready = rdy; halt = hlt; redirect_valid = rv; redirect_pc = rpc;
    if (!rstn) begin
      mq.delete(); mpc = 32'h0; mfc = 32'h0;
    end else if (rv) begin
      mq.delete(); mpc = rpc;
    end else begin
      pop_m  = (mq.size() > 0) && rdy;
      push_m = !hlt && ((mq.size() < DEPTH) || pop_m);
      if (pop_m) void'(mq.pop_front());
      if (push_m) begin
        mq.push_back({mpc, mem_word(mpc)});
        mpc = mpc + 32'd1;
        mfc = mfc + 32'd1;
      end
    end
    @(posedge clk);
    #1;
    check_output("out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
    check_output("out_ins", out_ins, (mq.size() > 0) ? mq[0][31:0] : 32'h0);
    check_output("out_pc", out_pc, (mq.size() > 0) ? mq[0][63:32] : 32'h0);
    check_output("fPC", fpc, mpc);
    check_output("fetch_count", fetch_count, mfc);
  endtask

  initial begin
    mpc = '0; mfc = '0;
    #2;
    // Scenario 1: first instructions after reset
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check_output("reset_valid", {31'b0, out_valid}, 32'h0);
    check_output("reset_count", fetch_count, 32'h0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check_output("t1_ins0", out_ins, 32'h0022_2020);
    check_output("t1_pc0", out_pc, 32'h0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check_output("t1_ins1", out_ins, 32'h0022_2022);
    check_output("t1_pc1", out_pc, 32'h1);

    // Scenario 2: stall with a full buffer, then drain in order
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check_output("t2_fpc_hold", fpc, 32'h2);
    check_output("t2_count", fetch_count, 32'h2);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

    // Scenario 3: redirect with a full buffer
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h8);
    check_output("t3_valid", {31'b0, out_valid}, 32'h0);
    check_output("t3_fpc", fpc, 32'h8);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check_output("t3_pc", out_pc, 32'h8);

    // Scenario 4: PC wraps past all-ones
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check_output("t4_pc0", out_pc, 32'hFFFF_FFFF);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check_output("t4_pc1", out_pc, 32'h0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check_output("t4_pc2", out_pc, 32'h1);

    // Scenario 5: halt drains the buffer and freezes fetch
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    saved_pc = fpc;
    saved_fc = fetch_count;
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check_output("t5_valid", {31'b0, out_valid}, 32'h0);
    check_output("t5_fpc", fpc, saved_pc);
    check_output("t5_count", fetch_count, saved_fc);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check_output("t5_resume", out_pc, saved_pc);

    // Scenario 6: reset mid-stream with a full buffer
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check_output("t6_valid", {31'b0, out_valid}, 32'h0);
    check_output("t6_count", fetch_count, 32'h0);
    check_output("t6_fpc", fpc, 32'h0);

    // Random phase
    for (int i = 0; i < 500; i++)
      apply_stimulus($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
